// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared types and default addresses for the PC sequencer.
package mips_pc_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {RUN, DELAY, HALTED} pc_state_t;
    localparam word_t RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam word_t HALT_ADDR_DEFAULT    = 32'h00000000;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect/stall inputs and PC status outputs of the PC sequencer.
interface pc_sequencer_if;
    import mips_pc_pkg::*;
    logic  stall;
    logic  branch_taken;
    word_t branch_addr;
    logic  jump;
    word_t jump_addr;
    word_t pc;
    word_t pcnext;
    logic  in_delay_slot;
    logic  active;
    logic  fault;
    modport master (output stall, branch_taken, branch_addr, jump, jump_addr,
                    input  pc, pcnext, in_delay_slot, active, fault);
    modport slave  (input  stall, branch_taken, branch_addr, jump, jump_addr,
                    output pc, pcnext, in_delay_slot, active, fault);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC with MIPS delay slot, stall hold and halt-on-jump-to-zero.
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirects instead of masking target[1:0].
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter word_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter word_t HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    pc_sequencer_if.slave bus
);
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    pc_state_t state;
    word_t     pc_q, target_q, target;
    logic      slot_q, active_q, fault_q, adv, redirect, misaligned;
    assign adv        = active_q & ~bus.stall;
    assign redirect   = bus.jump | bus.branch_taken;
    assign target     = bus.jump ? bus.jump_addr : bus.branch_addr;
    assign misaligned = TRAP_EN & redirect & (|target[1:0]);
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_VECTOR;
            state    <= RUN;
            target_q <= '0;
            slot_q   <= 1'b0;
            active_q <= 1'b1;
            fault_q  <= 1'b0;
        end else if (adv) begin
            case (state)
                RUN: begin
                    pc_q <= pc_q + 32'd4;
                    if (misaligned) begin
                        state    <= HALTED;
                        active_q <= 1'b0;
                        fault_q  <= 1'b1;
                    end else if (redirect) begin
                        target_q <= target & ~32'h3;
                        state    <= DELAY;
                        slot_q   <= 1'b1;
                    end
                end
                DELAY: begin
                    // Redirects seen here are a branch in the delay slot; the first target wins.
                    pc_q   <= target_q;
                    slot_q <= 1'b0;
                    if (target_q == HALT_ADDR) begin
                        state    <= HALTED;
                        active_q <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.pc            = pc_q;
    assign bus.pcnext        = pc_q + 32'd4;
    assign bus.in_delay_slot = slot_q;
    assign bus.active        = active_q;
    assign bus.fault         = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus against a behavioural PC model.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    pc_sequencer_if bus();
    pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    logic [31:0] m_pc, m_pending;
    logic        m_slot, m_halted, m_fault;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, bus.pc, m_pc);
        chk({tag, ".pcnext"}, bus.pcnext, m_pc + 32'd4);
        chk({tag, ".slot"}, {31'd0, bus.in_delay_slot}, {31'd0, m_slot});
        chk({tag, ".active"}, {31'd0, bus.active}, {31'd0, ~m_halted});
        chk({tag, ".fault"}, {31'd0, bus.fault}, {31'd0, m_fault});
    endtask
    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        m_pc = 32'hBFC00000; m_pending = 32'd0;
        m_slot = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        #1;
        reset = 1'b0;
        chk_all(tag);
    endtask
    task automatic step(input string tag, input logic st, input logic br, input logic [31:0] ba,
                        input logic j, input logic [31:0] ja);
        logic [31:0] tgt;
        bus.stall = st; bus.branch_taken = br; bus.branch_addr = ba;
        bus.jump = j; bus.jump_addr = ja;
        @(posedge clk);
        if (!m_halted && !st) begin
            if (m_slot) begin
                m_pc = m_pending;
                m_slot = 1'b0;
                m_halted = (m_pc == 32'd0);
            end else begin
                tgt = j ? ja : ba;
`ifdef PC_MISALIGN_TRAP_EN
                if ((j || br) && tgt[1:0] != 2'b00) begin
                    m_halted = 1'b1;
                    m_fault = 1'b1;
                end else
`endif
                if (j || br) begin
                    m_pending = {tgt[31:2], 2'b00};
                    m_slot = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        chk_all(tag);
    endtask
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask
    initial begin
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = '0;
        bus.jump = 1'b0; bus.jump_addr = '0;
        do_reset("reset");
        chk("reset_pc_const", bus.pc, 32'hBFC00000);
        idle("seq", 3);
        chk("seq_pc_const", bus.pc, 32'hBFC0000C);
        do_reset("br_reset");
        idle("br_pre", 2);
        step("br_take", 1'b0, 1'b1, 32'hBFC00040, 1'b0, 32'd0);
        chk("br_slot_pc", bus.pc, 32'hBFC0000C);
        chk("br_slot_flag", {31'd0, bus.in_delay_slot}, 32'd1);
        idle("br_tgt", 1);
        chk("br_tgt_pc", bus.pc, 32'hBFC00040);
        do_reset("stall_reset");
        idle("stall_pre", 2);
        step("stall_br", 1'b0, 1'b1, 32'hBFC00040, 1'b0, 32'd0);
        step("stall_1", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step("stall_2", 1'b1, 1'b1, 32'hBFC00200, 1'b0, 32'd0);
        chk("stall_hold_pc", bus.pc, 32'hBFC0000C);
        idle("stall_tgt", 1);
        chk("stall_tgt_pc", bus.pc, 32'hBFC00040);
        do_reset("halt_reset");
        step("halt_both", 1'b0, 1'b1, 32'hBFC00100, 1'b1, 32'd0);
        idle("halt_slot", 1);
        chk("halt_pc", bus.pc, 32'd0);
        chk("halt_active", {31'd0, bus.active}, 32'd0);
        for (int i = 0; i < 5; i++) step("halt_hold", 1'b0, 1'b1, 32'hBFC00100, 1'b1, 32'hBFC00300);
        chk("halt_hold_pc", bus.pc, 32'd0);
        do_reset("rd_reset");
        step("rd_br", 1'b0, 1'b1, 32'hBFC00080, 1'b0, 32'd0);
        do_reset("rd_mid_delay");
        idle("rd_after", 6);
        chk("rd_pc_const", bus.pc, 32'hBFC00018);
        do_reset("mis_reset");
        idle("mis_pre", 2);
        step("mis_br", 1'b0, 1'b1, 32'hBFC00042, 1'b0, 32'd0);
        idle("mis_post", 3);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_pc_const", bus.pc, 32'hBFC0000C);
        chk("mis_fault_const", {31'd0, bus.fault}, 32'd1);
`else
        chk("mis_pc_const", bus.pc, 32'hBFC00048);
`endif
        do_reset("wrap_reset");
        step("wrap_j", 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC);
        idle("wrap_tgt", 1);
        chk("wrap_pcnext", bus.pcnext, 32'd0);
        idle("wrap_over", 2);
        chk("wrap_pc", bus.pc, 32'd4);
        do_reset("rnd_reset");
        for (int i = 0; i < 400; i++) begin
            logic st, br, j;
            logic [31:0] ba, ja;
            st = ($urandom_range(3) == 0);
            br = ($urandom_range(4) == 0);
            j  = ($urandom_range(5) == 0);
            ba = 32'hBFC00000 | ($urandom_range(32'hFFFF) & 32'hFFFF);
            ja = ($urandom_range(11) == 0) ? 32'd0 : (32'hBFC00000 | ($urandom_range(32'hFFFF) & 32'hFFFC));
            if (m_halted && $urandom_range(3) == 0) do_reset("rnd_halt_reset");
            else if ($urandom_range(60) == 0) do_reset("rnd_reset");
            else step("rnd", st, br, ba, j, ja);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer end of the branch-target path: takes the computed branch target (PC+4 + sign-extended immediate << 2) and the jump target, and owns the architectural PC.
- Implements MIPS delay-slot semantics: a redirect takes effect one instruction later.
- Implements the stall handshake with instruction memory and the halt-on-jump-to-zero convention.
- Sits between decode/branch-compare logic and instruction fetch.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, redirect target that terminates execution once reached.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  fetch/memory not ready; PC and state hold.
- branch_taken  input  1  conditional branch resolved taken this cycle.
- branch_addr  input  32  branch target from the branch addressor.
- jump  input  1  unconditional jump (J/JAL/JR/JALR) this cycle.
- jump_addr  input  32  jump target.
- pc  output  32  address of the instruction currently being fetched.
- pcnext  output  32  pc + 4; feeds the branch addressor and link register.
- in_delay_slot  output  1  current pc is a delay-slot instruction.
- active  output  1  CPU running; low once halted.
- fault  output  1  misaligned redirect trap (only with the optional feature).

Behaviour:
- Reset (synchronous, active-high, overrides everything including stall):
  - pc = RESET_VECTOR; state = RUN; target_q = 0.
  - in_delay_slot = 0; active = 1; fault = 0.
- pcnext is combinational: pc + 4, 32-bit wrap-around with no overflow detection. 32'hFFFFFFFC + 4 = 0.
- Advance condition: `adv = active & ~stall`.
  - When adv = 0, all registers hold and redirect inputs are ignored.
  - The producer must hold branch_taken/jump and their targets until a non-stalled cycle.
- Redirect selection: jump has priority over branch_taken when both are asserted. target = jump ? jump_addr : branch_addr.
- States:
  - RUN, on adv:
    - If jump or branch_taken: target_q <= target; pc <= pc + 4; state -> DELAY.
    - Otherwise: pc <= pc + 4.
  - DELAY (in_delay_slot = 1), on adv:
    - pc <= target_q.
    - If target_q == HALT_ADDR: state -> HALTED.
    - Otherwise: state -> RUN.
    - Redirect inputs asserted in DELAY (branch in delay slot) are ignored; the first target wins.
  - HALTED: active = 0; pc holds HALT_ADDR; only reset exits.
- Latency:
  - Redirect sampled in cycle N (the branch instruction).
  - pc = branch + 4 (delay slot) in cycle N+1.
  - pc = target in cycle N+2, absent stalls. Stalls stretch each step independently.
- Stall in DELAY: target_q is held; the delay slot is not lost.
- Reset mid-DELAY: the pending target is discarded.
- Halt is observed as active falling on the same edge that pc becomes HALT_ADDR.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - When a redirect is accepted in RUN with target[1:0] != 0, the target is not latched; the block goes to HALTED with fault = 1.
  - pc = branch + 4 is held; active = 0.
  - fault clears only on reset.
- Undefined:
  - fault is tied to 0.
  - target[1:0] is forced to 2'b00 when latched into target_q.

Decomposition:
- Shared package mips_pc_pkg:
  - State enum pc_state_t {RUN, DELAY, HALTED}.
  - Constants RESET_VECTOR_DEFAULT = 32'hBFC00000 and HALT_ADDR_DEFAULT = 32'h0.
  - Typedef word_t = logic[31:0].
- No sub-module. Target selection and the +4 adder are inline. The branch addressor stays external.

Test Plan:
- Reset then 3 non-stalled cycles, no redirects -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; active = 1; in_delay_slot = 0.
- At pc = BFC00008, branch_taken = 1 with branch_addr = BFC00040 -> next pc = BFC0000C with in_delay_slot = 1, then pc = BFC00040 with in_delay_slot = 0.
- Same branch with stall = 1 for 2 cycles during DELAY -> pc holds BFC0000C for 2 cycles, then becomes BFC00040; target not lost.
- jump = 1 with jump_addr = 0 and branch_taken = 1 with branch_addr = BFC00100 simultaneously -> delay slot executes, then pc = 0, active = 0. pc stays 0 for 5 further cycles despite jump/branch stimulus.
- Reset asserted during DELAY (target BFC00080 pending) -> pc = BFC00000, state RUN. BFC00080 is never reached.
- With PC_MISALIGN_TRAP_EN: branch_addr = BFC00042 taken -> fault = 1, active = 0, pc frozen. Without the macro: pc reaches BFC00040 after the delay slot.
